// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven sequencer for a 4-bit up/down counter with
// output register. Accepts CLEAR/LOAD/COUNT/SNAPSHOT commands over a
// valid/ready channel, drives the counter control pins and returns
// sampled counter values (plus a wrap flag) over a valid/ready response channel.
module counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             cck,
    input  logic             cclr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [LEN_W-1:0] cmd_arg,
    output logic             ctr_cclr_n,
    output logic             ctr_load_n,
    output logic             ctr_enp_n,
    output logic             ctr_ent_n,
    output logic             ctr_updown,
    output logic [WIDTH-1:0] ctr_datain,
    output logic             ctr_rck,
    input  logic [WIDTH-1:0] ctr_q,
    input  logic             ctr_rco_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_wrap
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CLR  = 3'd1;
    localparam logic [2:0] LD   = 3'd2;
    localparam logic [2:0] CNT  = 3'd3;
    localparam logic [2:0] SNAP = 3'd4;
    localparam logic [2:0] SAMP = 3'd5;
    localparam logic [2:0] RESP = 3'd6;

    localparam logic [1:0] OP_CLEAR    = 2'd0;
    localparam logic [1:0] OP_LOAD     = 2'd1;
    localparam logic [1:0] OP_COUNT    = 2'd2;
    localparam logic [1:0] OP_SNAPSHOT = 2'd3;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_s;
    logic             updown_r;
    logic             updown_s;
    logic [WIDTH-1:0] datain_r;
    logic [WIDTH-1:0] datain_s;
    logic [WIDTH-1:0] rsp_data_r;
    logic [WIDTH-1:0] rsp_data_s;
    logic             rsp_wrap_r;
    logic             rsp_wrap_s;
    logic             cclr_n_r;
    logic             load_n_r;
    logic             en_n_r;
    logic             rck_r;
    logic             rsp_valid_r;
    logic             cmd_ready_s;
    logic             accept_s;

    // Ready only in IDLE and never while reset is asserted.
    always_comb begin
        cmd_ready_s = (state_r == IDLE) && cclr;
        accept_s    = cmd_valid && cmd_ready_s;
    end

    // Next-state and datapath-next computation for the command sequencer.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        updown_s   = updown_r;
        datain_s   = datain_r;
        rsp_data_s = rsp_data_r;
        rsp_wrap_s = rsp_wrap_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            state_s = CLR;
                        end
                        OP_LOAD: begin
                            state_s  = LD;
                            datain_s = cmd_arg[WIDTH-1:0];
                        end
                        OP_COUNT: begin
                            updown_s   = cmd_dir;
                            len_s      = cmd_arg;
                            rsp_wrap_s = 1'b0;
                            if (cmd_arg == LEN_ZERO) begin
                                state_s = SNAP;
                            end else begin
                                state_s = CNT;
                            end
                        end
                        OP_SNAPSHOT: begin
                            rsp_wrap_s = 1'b0;
                            state_s    = SNAP;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                state_s = IDLE;
            end
            LD: begin
                state_s = IDLE;
            end
            CNT: begin
                // Ripple carry is sampled on every edge that ends an enable cycle.
                if (!ctr_rco_n) begin
                    rsp_wrap_s = 1'b1;
                end else begin
                    rsp_wrap_s = rsp_wrap_r;
                end
                len_s = len_r - LEN_ONE;
                if (len_r <= LEN_ONE) begin
                    state_s = SNAP;
                end else begin
                    state_s = CNT;
                end
            end
            SNAP: begin
                state_s = SAMP;
            end
            SAMP: begin
                // Output register was strobed during SNAP, so ctr_q is now settled.
                rsp_data_s = ctr_q;
                state_s    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and pin registers; pins are decoded from the next state
    // so each control pin is active exactly during its state's cycle.
    always_ff @(posedge cck) begin
        if (!cclr) begin
            state_r     <= IDLE;
            len_r       <= {LEN_W{1'b0}};
            updown_r    <= 1'b1;
            datain_r    <= {WIDTH{1'b0}};
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_wrap_r  <= 1'b0;
            cclr_n_r    <= 1'b1;
            load_n_r    <= 1'b1;
            en_n_r      <= 1'b1;
            rck_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            updown_r    <= updown_s;
            datain_r    <= datain_s;
            rsp_data_r  <= rsp_data_s;
            rsp_wrap_r  <= rsp_wrap_s;
            cclr_n_r    <= (state_s != CLR);
            load_n_r    <= (state_s != LD);
            en_n_r      <= (state_s != CNT);
            rck_r       <= (state_s == SNAP);
            rsp_valid_r <= (state_s == RESP);
        end
    end

    assign cmd_ready  = cmd_ready_s;
    assign ctr_cclr_n = cclr_n_r;
    assign ctr_load_n = load_n_r;
    assign ctr_enp_n  = en_n_r;
    assign ctr_ent_n  = en_n_r;
    assign ctr_updown = updown_r;
    assign ctr_datain = datain_r;
    assign ctr_rck    = rck_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_wrap   = rsp_wrap_r;

endmodule
